mult_dot_acc: RTL and testbench
===============================

Name: mult_dot_acc

Overview:
- Downstream consumer of the combinational 8x8 shift-add multiplier.
- Accepts a stream of 2*SIZE-bit products over a valid/ready handshake and accumulates exactly LEN products into one dot-product result.
- Presents the result, plus a sticky saturation flag, on a valid/ready output handshake.
- Sequential wrapper that turns per-pair multiplier outputs into vector results.

Parameters:
- SIZE, 8, operand width of the upstream multiplier; the product input is 2*SIZE bits.
- LEN, 4, number of products per dot product; must be >= 1.
- ACC_W, 18, accumulator/result width; must be >= 2*SIZE.

Ports:
- clk  input  1  rising-edge clock; only clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort: discards the partial sum and returns to ACC; rst has priority over clear.
- in_valid  input  1  product on prod is valid.
- in_ready  output  1  block accepts a product this cycle.
- prod  input  2*SIZE  unsigned product from the multiplier.
- out_valid  output  1  acc_out/sat hold a completed result.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  dot-product result.
- sat  output  1  result was clamped during this dot product.

Behaviour:
- Reset (rst=1 at a clk edge): state=ACC, count=0, acc=0, acc_out=0, sat=0, out_valid=0. in_ready is 1 in the following cycle.
- State ACC:
  - in_ready=1, out_valid=0.
  - Accept happens when in_valid && in_ready.
  - On accept: acc <= sat_add(acc, prod zero-extended to ACC_W); count <= count+1.
  - On accept with count==LEN-1: acc_out <= sat_add(acc, prod); sat <= sticky flag OR this add's overflow; count <= 0; state <= DONE.
  - Cycles with in_valid=0: no change.
- State DONE:
  - in_ready=0, out_valid=1; acc_out and sat held stable.
  - On out_ready=1: state <= ACC, acc <= 0, sticky flag <= 0. out_valid drops the next cycle.
  - acc_out and sat keep their last values while in ACC.
- Latency and throughput:
  - out_valid rises the cycle after the LEN-th accept.
  - Minimum of LEN+1 cycles per result; there is no overlap of ACC and DONE.
- sat_add: compute the sum in ACC_W+1 bits. If bit ACC_W is set, the result is 2^ACC_W-1 and the sticky flag is set. Otherwise the result is the low ACC_W bits.
  - Once saturated, later adds remain at all-ones.
  - The sticky flag clears only on result handoff, clear, or rst.
- clear:
  - In ACC: acc=0, count=0, sticky=0; a product presented the same cycle is dropped, not accepted.
  - In DONE: discards the pending result; out_valid=0 the next cycle, state=ACC, sat=0.
- rst mid-operation: same as reset; the partial sum and any pending result are lost.
- LEN=1: every accept goes directly to DONE with acc_out=prod.
- Upstream may hold prod and in_valid across cycles. Only handshake cycles count, so a held product during DONE is not consumed.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release -> out_valid=0, acc_out=0, sat=0, in_ready=1.
- Basic dot product: products 10, 20, 30, 40 on 4 consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 4th accept, acc_out=100, sat=0, out_valid for exactly 1 cycle.
- Backpressure and gaps: products 5, 0, 7, 3 with idle cycles between them, out_ready=0 for 5 cycles after completion -> acc_out=15 held, in_ready=0 throughout DONE, and a 5th product presented during DONE is not consumed until ACC resumes.
- Saturation: ACC_W=16, products 65025, 65025, 1, 1 -> acc_out=65535, sat=1. The next run of 1, 2, 3, 4 -> acc_out=10, sat=0.
- clear mid-run: accept 100, 200, then clear=1 with in_valid=1 prod=999, then 1, 2, 3, 4 -> acc_out=10 (999 dropped).
- rst in DONE: complete 1, 1, 1, 1, then rst=1 while out_valid=1 -> out_valid=0, acc_out=0 the next cycle; a fresh run of 2, 2, 2, 2 gives 8.

Source files
------------

// File: rtl/mult_dot_acc.sv
// Dot-product accumulator: sums LEN unsigned products from the upstream multiplier
// with saturation, then hands the result downstream over a valid/ready handshake.
module mult_dot_acc #(
  parameter int SIZE  = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*SIZE-1:0]   prod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    acc_out,
  output logic                sat
);

  localparam int              CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int              SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [ACC_W-1:0]   acc;
  logic               sticky;

  logic               accept;
  logic               last_beat;
  logic               handoff;
  logic [SUM_W-1:0]   sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               sum_ovf;

  // Saturating add: the carry out of the ACC_W-bit sum is the overflow indicator.
  always_comb begin
    sum_wide = {1'b0, acc} + SUM_W'(prod);
    sum_ovf  = sum_wide[ACC_W];
    sum_sat  = sum_ovf ? '1 : sum_wide[ACC_W-1:0];
  end

  // A product presented alongside clear is dropped, never accepted.
  assign accept    = in_valid && in_ready && !clear;
  assign last_beat = accept && (count == LAST);
  assign handoff   = (state == ST_DONE) && out_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) state <= ST_ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      ST_ACC: begin
        if (!clear && last_beat) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (clear || out_ready) state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      acc     <= '0;
      sticky  <= 1'b0;
      acc_out <= '0;
      sat     <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      acc    <= '0;
      sticky <= 1'b0;
      if (state == ST_DONE) sat <= 1'b0;
    end else if (accept) begin
      acc    <= sum_sat;
      sticky <= sticky | sum_ovf;
      if (last_beat) begin
        count   <= '0;
        acc_out <= sum_sat;
        sat     <= sticky | sum_ovf;
      end else begin
        count <= count + 1'b1;
      end
    end else if (handoff) begin
      // acc_out/sat stay visible after handoff; only the running sum restarts.
      acc    <= '0;
      sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_dot_acc.sv
// Bench for mult_dot_acc: directed scenarios plus random traffic, checked against a
// product-list model on two instances (ACC_W=18 default and ACC_W=16 for saturation).
module tb_mult_dot_acc;

  localparam int SIZE = 8;
  localparam int LEN  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [15:0] prod;
  logic        out_ready;

  logic        in_ready18, out_valid18, sat18;
  logic [17:0] acc_out18;
  logic        in_ready16, out_valid16, sat16;
  logic [15:0] acc_out16;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: products collected since the last result, and the last result.
  bit      m_done;
  longint  m_items[$];
  longint  m_out18, m_out16;
  bit      m_sat18, m_sat16;

  always #5 clk = ~clk;

  mult_dot_acc #(.SIZE(SIZE), .LEN(LEN), .ACC_W(18)) u_dut18 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready18),
    .prod(prod), .out_valid(out_valid18), .out_ready(out_ready), .acc_out(acc_out18),
    .sat(sat18)
  );

  mult_dot_acc #(.SIZE(SIZE), .LEN(LEN), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .prod(prod), .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16),
    .sat(sat16)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model from the inputs held across the edge, then compare.
  task automatic tick();
    longint total;
    @(posedge clk);
    #1;
    if (rst) begin
      m_done = 0;
      m_items.delete();
      m_out18 = 0; m_out16 = 0;
      m_sat18 = 0; m_sat16 = 0;
    end else if (clear) begin
      if (m_done) begin
        m_done  = 0;
        m_sat18 = 0;
        m_sat16 = 0;
      end else begin
        m_items.delete();
      end
    end else if (!m_done) begin
      if (in_valid) begin
        m_items.push_back(longint'(prod));
        if (m_items.size() == LEN) begin
          total = 0;
          foreach (m_items[i]) total += m_items[i];
          m_sat18 = (total > 262143);
          m_out18 = m_sat18 ? 262143 : total;
          m_sat16 = (total > 65535);
          m_out16 = m_sat16 ? 65535 : total;
          m_items.delete();
          m_done = 1;
        end
      end
    end else if (out_ready) begin
      m_done = 0;
    end
    check("out_valid18", out_valid18, m_done);
    check("in_ready18",  in_ready18,  !m_done);
    check("acc_out18",   acc_out18,   m_out18);
    check("sat18",       sat18,       m_sat18);
    check("out_valid16", out_valid16, m_done);
    check("in_ready16",  in_ready16,  !m_done);
    check("acc_out16",   acc_out16,   m_out16);
    check("sat16",       sat16,       m_sat16);
  endtask

  task automatic drive(input bit v, input int p, input bit ordy, input bit clr, input bit rs);
    in_valid  = v;
    prod      = p[15:0];
    out_ready = ordy;
    clear     = clr;
    rst       = rs;
    tick();
  endtask

  task automatic run4(input int a, input int b, input int c, input int d);
    drive(1, a, 1, 0, 0);
    drive(1, b, 1, 0, 0);
    drive(1, c, 1, 0, 0);
    drive(1, d, 1, 0, 0);
  endtask

  initial begin
    int p;
    rst = 1; clear = 0; in_valid = 0; prod = '0; out_ready = 0;

    // Reset held for two cycles, then an idle cycle.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);

    // Basic dot product with immediate handoff.
    run4(10, 20, 30, 40);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Gaps between products, backpressure, and a held product during DONE.
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 9, 0, 0, 0);
    drive(1, 9, 1, 0, 0);
    drive(1, 9, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Saturation on the 16-bit instance, then a clean run clears sat.
    run4(65025, 65025, 1, 1);
    drive(0, 0, 1, 0, 0);
    run4(1, 2, 3, 4);
    drive(0, 0, 1, 0, 0);

    // clear mid-run drops the product offered alongside it.
    drive(1, 100, 0, 0, 0);
    drive(1, 200, 0, 0, 0);
    drive(1, 999, 0, 1, 0);
    run4(1, 2, 3, 4);
    drive(0, 0, 1, 0, 0);

    // clear while a result is pending.
    run4(65535, 65535, 7, 7);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);

    // rst while DONE, then a fresh run.
    run4(1, 1, 1, 1);
    drive(0, 0, 0, 0, 1);
    run4(2, 2, 2, 2);
    drive(0, 0, 1, 0, 0);

    // Random traffic with occasional clear and rst.
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 65535))
                                      : int'($urandom_range(0, 65535));
      drive($urandom_range(0, 2) != 0, p, $urandom_range(0, 1) == 1,
            $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
